// File: rtl/ex_result_buffer.sv
// Two-entry elastic result buffer between the ALU and writeback, with strict FIFO order and flush.
// Optional operand forwarding outputs are enabled by defining EXRB_FWD_EN.
module ex_result_buffer #(
    parameter int Width    = 32,
    parameter int RegAddrW = 5
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                flush,
    input  logic                inValid,
    output logic                inReady,
    input  logic [Width-1:0]    aluOut,
    input  logic                carry,
    input  logic                zero,
    input  logic [RegAddrW-1:0] rdAddr,
    input  logic                regWrite,
    output logic                outValid,
    input  logic                outReady,
    output logic [Width-1:0]    wbData,
    output logic                wbCarry,
    output logic                wbZero,
    output logic [RegAddrW-1:0] wbRd,
    output logic                wbRegWrite,
    output logic [1:0]          level
`ifdef EXRB_FWD_EN
    ,
    output logic                fwdValid,
    output logic [RegAddrW-1:0] fwdRd,
    output logic [Width-1:0]    fwdData
`endif
);

    typedef struct packed {
        logic [Width-1:0]    data;
        logic                carry;
        logic                zero;
        logic [RegAddrW-1:0] rd;
        logic                rw;
    } entry_t;

    // A write to register 0 is dropped at capture so it can never reach the register file.
    function automatic entry_t capture(
        input logic [Width-1:0]    d,
        input logic                c,
        input logic                z,
        input logic [RegAddrW-1:0] rd,
        input logic                rw
    );
        entry_t e;
        e.data  = d;
        e.carry = c;
        e.zero  = z;
        e.rd    = rd;
        e.rw    = rw & (rd != '0);
        return e;
    endfunction

    entry_t     head_p0;
    entry_t     tail_p0;
    logic [1:0] lvl_p0;
    entry_t     in_entry;
    logic       push;
    logic       pop;

    assign in_entry = capture(aluOut, carry, zero, rdAddr, regWrite);

    // Handshake qualifiers come only from registered occupancy.
    assign inReady  = (lvl_p0 != 2'd2);
    assign outValid = (lvl_p0 != 2'd0);
    assign push     = inValid & inReady;
    assign pop      = outValid & outReady;

    // Stage p0: head/tail storage and occupancy; the tail only exists while level is 2.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lvl_p0  <= 2'd0;
            head_p0 <= '0;
            tail_p0 <= '0;
        end else if (flush) begin
            lvl_p0 <= 2'd0;
        end else begin
            case (lvl_p0)
                2'd0: begin
                    if (push) begin
                        head_p0 <= in_entry;
                        lvl_p0  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_p0 <= in_entry;
                    end else if (push) begin
                        tail_p0 <= in_entry;
                        lvl_p0  <= 2'd2;
                    end else if (pop) begin
                        lvl_p0 <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_p0 <= tail_p0;
                        lvl_p0  <= 2'd1;
                    end
                end
                default: lvl_p0 <= 2'd0;
            endcase
        end
    end

    assign level = lvl_p0;

    always_comb begin
        wbData     = '0;
        wbCarry    = 1'b0;
        wbZero     = 1'b0;
        wbRd       = '0;
        wbRegWrite = 1'b0;
        if (outValid) begin
            wbData     = head_p0.data;
            wbCarry    = head_p0.carry;
            wbZero     = head_p0.zero;
            wbRd       = head_p0.rd;
            wbRegWrite = head_p0.rw;
        end
    end

`ifdef EXRB_FWD_EN
    // The youngest qualifying entry wins: tail when present and writing, otherwise head.
    always_comb begin
        fwdValid = 1'b0;
        fwdRd    = '0;
        fwdData  = '0;
        if ((lvl_p0 == 2'd2) && tail_p0.rw) begin
            fwdValid = 1'b1;
            fwdRd    = tail_p0.rd;
            fwdData  = tail_p0.data;
        end else if ((lvl_p0 != 2'd0) && head_p0.rw) begin
            fwdValid = 1'b1;
            fwdRd    = head_p0.rd;
            fwdData  = head_p0.data;
        end
    end
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed plus randomised bench for ex_result_buffer using a queue model of held entries.
module tb_ex_result_buffer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] aluOut;
    logic        carry;
    logic        zero;
    logic [4:0]  rdAddr;
    logic        regWrite;
    logic        outValid;
    logic        outReady;
    logic [31:0] wbData;
    logic        wbCarry;
    logic        wbZero;
    logic [4:0]  wbRd;
    logic        wbRegWrite;
    logic [1:0]  level;
`ifdef EXRB_FWD_EN
    logic        fwdValid;
    logic [4:0]  fwdRd;
    logic [31:0] fwdData;
`endif

    ex_result_buffer #(.Width(32), .RegAddrW(5)) dut (
        .clk(clk), .rstN(rstN), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .aluOut(aluOut), .carry(carry), .zero(zero),
        .rdAddr(rdAddr), .regWrite(regWrite),
        .outValid(outValid), .outReady(outReady),
        .wbData(wbData), .wbCarry(wbCarry), .wbZero(wbZero),
        .wbRd(wbRd), .wbRegWrite(wbRegWrite), .level(level)
`ifdef EXRB_FWD_EN
        , .fwdValid(fwdValid), .fwdRd(fwdRd), .fwdData(fwdData)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        z;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic check_state(input string tag);
        int n;
        n = q.size();
        chk({tag, ".level"}, 64'(level), 64'(n));
        chk({tag, ".outValid"}, 64'(outValid), 64'(n != 0));
        chk({tag, ".inReady"}, 64'(inReady), 64'(n != 2));
        if (n == 0) begin
            chk({tag, ".wbzero"}, {25'd0, wbData, wbCarry, wbZero, wbRd, wbRegWrite}, 64'd0);
        end else begin
            chk({tag, ".wbData"}, 64'(wbData), 64'(q[0].d));
            chk({tag, ".wbCarry"}, 64'(wbCarry), 64'(q[0].c));
            chk({tag, ".wbZero"}, 64'(wbZero), 64'(q[0].z));
            chk({tag, ".wbRd"}, 64'(wbRd), 64'(q[0].rd));
            chk({tag, ".wbRegWrite"}, 64'(wbRegWrite), 64'(q[0].rw));
        end
`ifdef EXRB_FWD_EN
        begin
            logic       ev;
            logic [4:0] erd;
            logic [31:0] ed;
            ev = 1'b0; erd = '0; ed = '0;
            if (n == 2 && q[1].rw) begin
                ev = 1'b1; erd = q[1].rd; ed = q[1].d;
            end else if (n >= 1 && q[0].rw) begin
                ev = 1'b1; erd = q[0].rd; ed = q[0].d;
            end
            chk({tag, ".fwdValid"}, 64'(fwdValid), 64'(ev));
            chk({tag, ".fwdRd"}, 64'(fwdRd), 64'(erd));
            chk({tag, ".fwdData"}, 64'(fwdData), 64'(ed));
        end
`endif
    endtask

    // One clock cycle: drive inputs, update the model at the edge, then compare.
    task automatic step(input string tag, input logic iv, input logic [31:0] d,
                        input logic c, input logic z, input logic [4:0] rd, input logic rw,
                        input logic ordy, input logic fl);
        logic mpush, mpop;
        exp_t e;
        inValid = iv; aluOut = d; carry = c; zero = z;
        rdAddr = rd; regWrite = rw; outReady = ordy; flush = fl;
        #1;
        mpush = iv && (q.size() != 2);
        mpop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                e.d = d; e.c = c; e.z = z; e.rd = rd; e.rw = rw && (rd != 5'd0);
                q.push_back(e);
            end
        end
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; aluOut = '0; carry = 1'b0;
        zero = 1'b0; rdAddr = '0; regWrite = 1'b0; outReady = 1'b0;
        #12;
        check_state("reset");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Single entry through with writeback ready.
        step("t1.push", 1'b1, 32'h5, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("t1.wbData_const", 64'(wbData), 64'h5);
        chk("t1.wbRd_const", 64'(wbRd), 64'd3);
        idle("t1.drain", 1'b1);

        // Fill to two, third is refused, then drain in order.
        step("t2.pushA", 1'b1, 32'hA, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        step("t2.pushB", 1'b1, 32'hB, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("t2.inReady_full", 64'(inReady), 64'd0);
        step("t2.refused", 1'b1, 32'hC, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        idle("t2.popA", 1'b1);
        chk("t2.headB", 64'(wbData), 64'hB);
        idle("t2.popB", 1'b1);

        // Simultaneous push and pop at level 1.
        step("t3.pushA", 1'b1, 32'hA, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step("t3.pushpop", 1'b1, 32'hC, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        chk("t3.headC", 64'(wbData), 64'hC);
        idle("t3.drain", 1'b1);

        // Write to x0 is suppressed but the data still travels.
        step("t4.x0", 1'b1, 32'h1234, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("t4.wbRegWrite_const", 64'(wbRegWrite), 64'd0);
        chk("t4.wbData_const", 64'(wbData), 64'h1234);
        idle("t4.drain", 1'b1);

        // Flush at level 2 drops held entries and the concurrent input.
        step("t5.p1", 1'b1, 32'h51, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        step("t5.p2", 1'b1, 32'h52, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step("t5.flush", 1'b1, 32'h53, 1'b1, 1'b1, 5'd10, 1'b1, 1'b1, 1'b1);
        chk("t5.level_const", 64'(level), 64'd0);
        idle("t5.after", 1'b1);

        // Youngest qualifying entry drives forwarding.
        step("t6.p4", 1'b1, 32'h11, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step("t6.p7", 1'b1, 32'h22, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
`ifdef EXRB_FWD_EN
        chk("t6.fwdRd_const", 64'(fwdRd), 64'd7);
        chk("t6.fwdData_const", 64'(fwdData), 64'h22);
`endif
        idle("t6.pop1", 1'b1);
`ifdef EXRB_FWD_EN
        chk("t6.fwdRd_pop1", 64'(fwdRd), 64'd7);
`endif
        idle("t6.pop2", 1'b1);
`ifdef EXRB_FWD_EN
        chk("t6.fwdValid_pop2", 64'(fwdValid), 64'd0);
`endif

        // Asynchronous reset mid-transfer empties the buffer immediately.
        step("t7.p1", 1'b1, 32'h71, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        step("t7.p2", 1'b1, 32'h72, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        inValid = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        #1;
        q.delete();
        check_state("t7.async");
        @(negedge clk);
        rstN = 1'b1;
        step("t7.first", 1'b1, 32'h73, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        idle("t7.drain", 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        idle("end.drain1", 1'b1);
        idle("end.drain2", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
